// File: rtl/sdram_burst_dpath.sv
// SDRAM burst data path: sequences fixed-length write and read bursts on the DQ/DQM pins.
// Write words are registered one cycle before they reach the bus; read words are captured CL cycles after the command.
module sdram_burst_dpath #(
    parameter int DW = 16,
    parameter int BL = 8,
    parameter int CL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_start,
    input  logic              i_rd_start,
    input  logic              i_burst_stop,
    input  logic [DW-1:0]     i_wr_data,
    input  logic [DW/8-1:0]   i_wr_mask,
    output logic              o_wr_req,
    output logic [DW-1:0]     o_rd_data,
    output logic              o_rd_valid,
    inout  wire  [DW-1:0]     io_sdram_dq,
    output logic [DW/8-1:0]   o_sdram_dqm,
    output logic              o_busy,
    output logic              o_burst_done,
    output logic              o_cmd_err,
    output logic [1:0]        o_dbg_state,
    output logic              o_dbg_oe
);
    localparam int            CW         = $clog2(BL) + 1;
    localparam logic [CW-1:0] C_BL       = CW'(BL);
    localparam logic [CW-1:0] C_LAST     = CW'(BL - 1);
    localparam logic [CW-1:0] C_LAT_LAST = CW'(CL - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        RD_LAT = 2'd2,
        READ   = 2'd3
    } state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic            w_wr_req, w_sample, w_done, w_err;
    logic            r_oe, r_rd_valid, r_done, r_err;
    logic [DW-1:0]   r_wdata, r_rd_data;
    logic [DW/8-1:0] r_dqm;

    // Handshakes: o_wr_req=1 means i_wr_data/i_wr_mask are consumed at the coming edge (no back-pressure);
    // o_rd_valid=1 means o_rd_data holds a new word for exactly this cycle (no ready, consumer must keep up).
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_wr_req   = 1'b0;
        w_sample   = 1'b0;
        w_done     = 1'b0;
        w_err      = (r_state != IDLE) && (i_wr_start || i_rd_start);
        case (r_state)
            IDLE: begin
                if (i_wr_start) begin
                    w_wr_req   = 1'b1;
                    w_next     = WRITE;
                    w_cnt_next = CW'(1);
                    w_err      = i_rd_start;
                end else if (i_rd_start) begin
                    w_next     = RD_LAT;
                    w_cnt_next = '0;
                end
            end
            WRITE: begin
                // r_cnt counts consumed words; the state lingers one cycle to drive the last one.
                if ((r_cnt < C_BL) && !i_burst_stop) begin
                    w_wr_req   = 1'b1;
                    w_cnt_next = r_cnt + 1'b1;
                end else begin
                    w_next     = IDLE;
                    w_cnt_next = '0;
                    w_done     = 1'b1;
                end
            end
            RD_LAT: begin
                if (i_burst_stop) begin
                    w_next     = IDLE;
                    w_cnt_next = '0;
                    w_done     = 1'b1;
                end else if (r_cnt == C_LAT_LAST) begin
                    w_next     = READ;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            READ: begin
                if (i_burst_stop) begin
                    w_next     = IDLE;
                    w_cnt_next = '0;
                    w_done     = 1'b1;
                end else begin
                    w_sample = 1'b1;
                    if (r_cnt == C_LAST) begin
                        w_next     = IDLE;
                        w_cnt_next = '0;
                        w_done     = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_oe       <= 1'b0;
            r_wdata    <= '0;
            r_dqm      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            r_oe       <= w_wr_req;
            r_dqm      <= w_wr_req ? i_wr_mask : '0;
            r_rd_valid <= w_sample;
            r_done     <= w_done;
            r_err      <= w_err;
            if (w_wr_req) begin
                r_wdata <= i_wr_data;
            end
            if (w_sample) begin
                r_rd_data <= io_sdram_dq;
            end
        end
    end

    assign io_sdram_dq  = r_oe ? r_wdata : {DW{1'bz}};
    assign o_wr_req     = w_wr_req;
    assign o_sdram_dqm  = r_dqm;
    assign o_rd_data    = r_rd_data;
    assign o_rd_valid   = r_rd_valid;
    assign o_busy       = (r_state != IDLE);
    assign o_burst_done = r_done;
    assign o_cmd_err    = r_err;
    assign o_dbg_state  = r_state;
    assign o_dbg_oe     = r_oe;
endmodule

// File: tb/tb_sdram_burst_dpath.sv
// Bench for sdram_burst_dpath: cycle-by-cycle vector table on a BL=8/CL=2 and a BL=1/CL=3 instance,
// plus a hand-written reset-in-the-middle-of-a-read sequence.
module tb_sdram_burst_dpath;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]       ws, rs, stop, drv;
    logic [1:0][15:0] wd, dq_in;
    logic [1:0][1:0]  wm;
    wire  [1:0]       wr_req, rv, busy, done, err, oe;
    wire  [1:0][15:0] rd_data;
    wire  [1:0][1:0]  dqm, st;
    wire  [15:0]      a_dq, b_dq;

    // Memory model: drives the bus only in the cycles a vector asks for.
    assign a_dq = drv[0] ? dq_in[0] : 16'bz;
    assign b_dq = drv[1] ? dq_in[1] : 16'bz;

    sdram_burst_dpath #(.DW(16), .BL(8), .CL(2)) u_a (
        .clk(clk), .rst_n(rst_n),
        .i_wr_start(ws[0]), .i_rd_start(rs[0]), .i_burst_stop(stop[0]),
        .i_wr_data(wd[0]), .i_wr_mask(wm[0]),
        .o_wr_req(wr_req[0]), .o_rd_data(rd_data[0]), .o_rd_valid(rv[0]),
        .io_sdram_dq(a_dq), .o_sdram_dqm(dqm[0]), .o_busy(busy[0]),
        .o_burst_done(done[0]), .o_cmd_err(err[0]),
        .o_dbg_state(st[0]), .o_dbg_oe(oe[0])
    );

    sdram_burst_dpath #(.DW(16), .BL(1), .CL(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .i_wr_start(ws[1]), .i_rd_start(rs[1]), .i_burst_stop(stop[1]),
        .i_wr_data(wd[1]), .i_wr_mask(wm[1]),
        .o_wr_req(wr_req[1]), .o_rd_data(rd_data[1]), .o_rd_valid(rv[1]),
        .io_sdram_dq(b_dq), .o_sdram_dqm(dqm[1]), .o_busy(busy[1]),
        .o_burst_done(done[1]), .o_cmd_err(err[1]),
        .o_dbg_state(st[1]), .o_dbg_oe(oe[1])
    );

    typedef struct {
        int          u;
        logic        ws, rs, stop, drv;
        logic [15:0] wd, dq_in;
        logic [1:0]  wm;
        logic        e_req, e_oe, e_rv, e_busy, e_done, e_err;
        logic [15:0] e_dq, e_rd;
        logic [1:0]  e_dqm;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vq[$];

    function automatic vec_t nop(input int u);
        vec_t v;
        v   = '{default: '0};
        v.u = u;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_reset(input int u);
        chk("rst_wr_req", u, 32'(wr_req[u]), 0);
        chk("rst_rd_valid", u, 32'(rv[u]), 0);
        chk("rst_rd_data", u, 32'(rd_data[u]), 0);
        chk("rst_oe", u, 32'(oe[u]), 0);
        chk("rst_dqm", u, 32'(dqm[u]), 0);
        chk("rst_busy", u, 32'(busy[u]), 0);
        chk("rst_done", u, 32'(done[u]), 0);
        chk("rst_err", u, 32'(err[u]), 0);
        chk("rst_state", u, 32'(st[u]), 0);
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [15:0] bus;
        @(negedge clk);
        ws = '0; rs = '0; stop = '0; drv = '0; wd = '0; wm = '0; dq_in = '0;
        ws[v.u]    = v.ws;
        rs[v.u]    = v.rs;
        stop[v.u]  = v.stop;
        drv[v.u]   = v.drv;
        wd[v.u]    = v.wd;
        wm[v.u]    = v.wm;
        dq_in[v.u] = v.dq_in;
        #1;
        bus = (v.u == 0) ? a_dq : b_dq;
        chk("wr_req", idx, 32'(wr_req[v.u]), 32'(v.e_req));
        chk("dq_oe", idx, 32'(oe[v.u]), 32'(v.e_oe));
        chk("dqm", idx, 32'(dqm[v.u]), 32'(v.e_dqm));
        chk("rd_valid", idx, 32'(rv[v.u]), 32'(v.e_rv));
        chk("busy", idx, 32'(busy[v.u]), 32'(v.e_busy));
        chk("burst_done", idx, 32'(done[v.u]), 32'(v.e_done));
        chk("cmd_err", idx, 32'(err[v.u]), 32'(v.e_err));
        if (v.e_oe) chk("dq", idx, 32'(bus), 32'(v.e_dq));
        if (v.e_rv) chk("rd_data", idx, 32'(rd_data[v.u]), 32'(v.e_rd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // Write burst 1000..1007, stray rd_start in its 4th cycle.
        for (int k = 0; k < 9; k++) begin
            v = nop(0);
            v.ws = (k == 0);
            v.rs = (k == 3);
            if (k <= 7) begin v.wd = 16'h1000 + 16'(k); v.e_req = 1'b1; end
            if (k >= 1) begin v.e_oe = 1'b1; v.e_dq = 16'h1000 + 16'(k - 1); v.e_busy = 1'b1; end
            v.e_err = (k == 4);
            vq.push_back(v);
        end
        // Read issued back-to-back in the write's done cycle; bus carries A0..A7.
        for (int j = 0; j <= 10; j++) begin
            v = nop(0);
            v.rs     = (j == 0);
            v.e_busy = (j >= 1 && j <= 9);
            if (j >= 2 && j <= 9) begin v.drv = 1'b1; v.dq_in = 16'h00A0 + 16'(j - 2); end
            if (j >= 3) begin v.e_rv = 1'b1; v.e_rd = 16'h00A0 + 16'(j - 3); end
            v.e_done = (j == 0 || j == 10);
            vq.push_back(v);
        end
        // Simultaneous wr_start+rd_start: write wins, per-word masks follow their data.
        for (int k = 0; k <= 9; k++) begin
            v = nop(0);
            v.ws = (k == 0);
            v.rs = (k == 0);
            if (k <= 7) begin v.wd = 16'h2000 + 16'(k); v.wm = 2'(k); v.e_req = 1'b1; end
            if (k >= 1 && k <= 8) begin
                v.e_oe = 1'b1; v.e_dq = 16'h2000 + 16'(k - 1); v.e_dqm = 2'(k - 1); v.e_busy = 1'b1;
            end
            v.e_err  = (k == 1);
            v.e_done = (k == 9);
            vq.push_back(v);
        end
        // burst_stop on the 4th write word, then burst_stop while idle.
        for (int k = 0; k <= 5; k++) begin
            v = nop(0);
            v.ws   = (k == 0);
            v.stop = (k == 3 || k == 5);
            if (k <= 3) v.wd = 16'h3000 + 16'(k);
            v.e_req = (k <= 2);
            if (k >= 1 && k <= 3) begin v.e_oe = 1'b1; v.e_dq = 16'h3000 + 16'(k - 1); v.e_busy = 1'b1; end
            v.e_done = (k == 4);
            vq.push_back(v);
        end
        // burst_stop during READ after two words captured.
        for (int j = 0; j <= 6; j++) begin
            v = nop(0);
            v.rs   = (j == 0);
            v.stop = (j == 4);
            v.e_busy = (j >= 1 && j <= 4);
            if (j >= 2 && j <= 5) begin v.drv = 1'b1; v.dq_in = 16'h00B0 + 16'(j - 2); end
            if (j == 3 || j == 4) begin v.e_rv = 1'b1; v.e_rd = 16'h00B0 + 16'(j - 3); end
            v.e_done = (j == 5);
            vq.push_back(v);
        end
        // BL=1, CL=3 instance: single masked write, then single read.
        for (int k = 0; k <= 2; k++) begin
            v = nop(1);
            if (k == 0) begin v.ws = 1'b1; v.wd = 16'h3456; v.wm = 2'b10; v.e_req = 1'b1; end
            if (k == 1) begin v.e_oe = 1'b1; v.e_dq = 16'h3456; v.e_dqm = 2'b10; v.e_busy = 1'b1; end
            v.e_done = (k == 2);
            vq.push_back(v);
        end
        for (int j = 0; j <= 4; j++) begin
            v = nop(1);
            v.rs     = (j == 0);
            v.e_busy = (j >= 1 && j <= 3);
            if (j == 3) begin v.drv = 1'b1; v.dq_in = 16'h5A5A; end
            if (j == 4) begin v.e_rv = 1'b1; v.e_rd = 16'h5A5A; v.e_done = 1'b1; end
            vq.push_back(v);
        end

        rst_n = 1'b0;
        ws = '0; rs = '0; stop = '0; drv = '0; wd = '0; wm = '0; dq_in = '0;
        #12;
        chk_reset(0);
        chk_reset(1);
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

        // Reset asserted right after the 3rd rd_valid of a read burst.
        for (int j = 0; j <= 5; j++) begin
            v = nop(0);
            v.rs     = (j == 0);
            v.e_busy = (j >= 1);
            if (j >= 2) begin v.drv = 1'b1; v.dq_in = 16'h00C0 + 16'(j - 2); end
            if (j >= 3) begin v.e_rv = 1'b1; v.e_rd = 16'h00C0 + 16'(j - 3); end
            apply(v, 1000 + j);
        end
        #1 rst_n = 1'b0;
        drv = '0;
        #1 chk_reset(0);
        @(posedge clk);
        #2 chk_reset(0);
        rst_n = 1'b1;
        // Fresh read on the first edge after release; no burst_done left over from the aborted one.
        for (int j = 0; j <= 10; j++) begin
            v = nop(0);
            v.rs     = (j == 0);
            v.e_busy = (j >= 1 && j <= 9);
            if (j >= 2 && j <= 9) begin v.drv = 1'b1; v.dq_in = 16'h00D0 + 16'(j - 2); end
            if (j >= 3) begin v.e_rv = 1'b1; v.e_rd = 16'h00D0 + 16'(j - 3); end
            v.e_done = (j == 10);
            apply(v, 2000 + j);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_burst_dpath.md
SDRAM_BURST_DPATH -- requirements
Module: sdram_burst_dpath

Interface
REQ-001 SHALL provide parameter DW, default 16, SDRAM data width in bits (multiple of 8).
REQ-002 SHALL provide parameter BL, default 8, burst length in words (1..256).
REQ-003 SHALL provide parameter CL, default 2, CAS latency in cycles (2 or 3).
REQ-004 SHALL provide ports: clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-005 SHALL provide ports: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL provide ports: wr_start  input  1  one-cycle pulse, WRITE command issued this cycle.
REQ-007 SHALL provide ports: rd_start  input  1  one-cycle pulse, READ command issued this cycle.
REQ-008 SHALL provide ports: burst_stop  input  1  terminate the current burst early.
REQ-009 SHALL provide ports: wr_data  input  DW  write word, valid in any cycle wr_req=1.
REQ-010 SHALL provide ports: wr_mask  input  DW/8  byte mask for wr_data, 1=masked.
REQ-011 SHALL provide ports: wr_req  output  1  request/consume one write word this cycle.
REQ-012 SHALL provide ports: rd_data  output  DW  captured read word.
REQ-013 SHALL provide ports: rd_valid  output  1  rd_data holds a new word this cycle.
REQ-014 SHALL provide ports: sdram_dq  inout  DW  SDRAM data bus.
REQ-015 SHALL provide ports: sdram_dqm  output  DW/8  SDRAM byte mask.
REQ-016 SHALL provide ports: busy  output  1  FSM not in IDLE.
REQ-017 SHALL provide ports: burst_done  output  1  one-cycle pulse at burst end.
REQ-018 SHALL provide ports: cmd_err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-019 SHALL implement FSM states IDLE, WRITE, RD_LAT, READ; busy=1 in any state except IDLE.
REQ-020 In IDLE, wr_start at edge t SHALL enter WRITE; wr_req=1 in cycles t..t+BL-1 (combinational on state/start); word counter 0..BL-1.
REQ-021 Each word consumed SHALL be registered; sdram_dq driven with it and sdram_dqm with its mask one cycle later, i.e. cycles t+1..t+BL; output enable registered.
REQ-022 sdram_dq SHALL be high-Z whenever output enable is 0; sdram_dqm SHALL be 0 when not driving write data.
REQ-023 After the last write word, FSM SHALL return to IDLE; burst_done SHALL pulse in cycle t+BL+1 (first cycle after last driven word).
REQ-024 In IDLE, rd_start at edge t SHALL enter RD_LAT for CL-1 cycles, then READ for BL cycles; sdram_dq sampled at edges t+CL..t+CL+BL-1.
REQ-025 rd_data/rd_valid SHALL be registered: rd_valid=1 in cycles t+CL+1..t+CL+BL, one word per cycle, in bus order.
REQ-026 For reads, burst_done SHALL pulse in the same cycle as the last rd_valid.
REQ-027 wr_start and rd_start together in IDLE: write SHALL be accepted, read rejected with cmd_err pulse next cycle.
REQ-028 Any wr_start or rd_start while busy=1 SHALL be ignored and cmd_err SHALL pulse next cycle.
REQ-029 burst_stop in WRITE SHALL end word consumption that cycle (wr_req=0 that cycle), drive no further words after those already registered, return to IDLE, pulse burst_done after the last driven word.
REQ-030 burst_stop in RD_LAT or READ SHALL return to IDLE next cycle; rd_valid SHALL stay 0 from the following cycle; burst_done SHALL pulse once.
REQ-031 burst_stop in IDLE SHALL have no effect.
REQ-032 A new start SHALL be accepted in the cycle FSM is back in IDLE (back-to-back bursts, no bubble beyond CL/BL timing).
REQ-033 Counters SHALL be ceil(log2(BL))+1 bits wide; no wrap beyond BL-1.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, counters 0, output enable 0 (sdram_dq high-Z), and rd_data=0, rd_valid=0, wr_req=0, sdram_dqm=0, busy=0, burst_done=0, cmd_err=0.
REQ-035 Reset asserted mid-burst SHALL abort it with no burst_done; first start accepted on the first edge after rst_n rises.

Verification (DW=16, BL=8, CL=2)
REQ-036 wr_start at t, wr_data 16'h1000..16'h1007, mask 0 -> dq carries same words t+1..t+8, high-Z at t+9, burst_done at t+9.
REQ-037 rd_start at t, model drives 16'hA0..16'hA7 at edges t+2..t+9 -> rd_valid t+3..t+10 with those words, burst_done at t+10.
REQ-038 wr_start and rd_start same cycle -> write burst only, cmd_err one cycle; rd_start during write -> cmd_err, burst unaffected.
REQ-039 burst_stop at 4th write word -> exactly 3 words driven, wr_req low from stop cycle, single burst_done, busy low after.
REQ-040 rst_n low mid read (after 3rd rd_valid) -> all outputs 0 and dq high-Z at once; new rd_start after release completes normally.
REQ-041 Repeat 036/037 with CL=3, BL=1, and wr_mask=2'b10 -> timing shifts by CL, single word, sdram_dqm=2'b10 aligned with data.
